// File: rtl/cluster_mem_bridge_pkg.sv
// Shared definitions for the cluster-to-DRAM bridge: funct3 codes, access sizes,
// bridge state encoding and the alignment rule.
package cluster_mem_bridge_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } bridge_state_e;

  // Size code 2'b11 is not a legal funct3 size; it is treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/cluster_mem_bridge_lane_format.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational; driven from the bridge's latched request.
module mem_lane_format
  import cluster_mem_bridge_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the raw DRAM word
  always_comb begin
    byte_s = raw_rdata[7:0];
    case (addr_lo)
      2'b00:   byte_s = raw_rdata[7:0];
      2'b01:   byte_s = raw_rdata[15:8];
      2'b10:   byte_s = raw_rdata[23:16];
      2'b11:   byte_s = raw_rdata[31:24];
      default: byte_s = raw_rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = raw_rdata[31:16];
    end else begin
      half_s = raw_rdata[15:0];
    end
  end

  // Size-dependent byte enables, replicated store data and extended load data
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    load_data  = raw_rdata;
    case (ctrl[1:0])
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        if (ctrl[2]) begin
          load_data = {24'h00_0000, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        if (ctrl[2]) begin
          load_data = {16'h0000, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = raw_rdata;
      end
    endcase
  end

endmodule

// File: rtl/cluster_mem_bridge.sv
// Runs the cluster's single outstanding access on the DRAM req/ack port:
// request latching, read / write / read-modify-write sequencing and timeout abort.
module cluster_mem_bridge
  import cluster_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter bit RMW_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_ctrl,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_err,
  output logic        o_dram_req,
  output logic        o_dram_we,
  output logic [31:0] o_dram_addr,
  output logic [3:0]  o_dram_be,
  output logic [31:0] o_dram_wdata,
  input  logic        i_dram_ack,
  input  logic [31:0] i_dram_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  bridge_state_e state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   addr_r;
  logic [2:0]    ctrl_r;
  logic [31:0]   wdata_r;
  logic          we_r;
  logic          rvalid_r;
  logic          err_r;
  logic [31:0]   rdata_r;

  logic          request_s;
  logic          misalign_s;
  logic          accept_s;
  logic          timeout_s;
  logic          busy_s;
  logic [31:0]   load_s;

  assign request_s  = i_re | i_we;
  assign misalign_s = is_misaligned(i_ctrl[1:0], i_addr[1:0]);

  mem_lane_format u_lane (
    .ctrl       (ctrl_r),
    .addr_lo    (addr_r[1:0]),
    .wdata      (wdata_r),
    .raw_rdata  (i_dram_rdata),
    .be         (o_dram_be),
    .lane_wdata (o_dram_wdata),
    .load_data  (load_s)
  );

  // Next state, beat timeout counter and cluster stall
  always_comb begin
    state_s   = state_r;
    cnt_s     = '0;
    accept_s  = 1'b0;
    timeout_s = 1'b0;
    busy_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = request_s;
        if (request_s) begin
          accept_s = 1'b1;
          if (misalign_s) begin
            state_s = ST_RESP;
          end else if (i_re && (RMW_EN || !i_we)) begin
            state_s = ST_RD;
          end else begin
            state_s = ST_WR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        busy_s = 1'b1;
        if (i_dram_ack) begin
          if ((state_r == ST_RD) && we_r && RMW_EN) begin
            state_s = ST_WR;
          end else begin
            state_s = ST_RESP;
          end
        end else if ((TIMEOUT > 0) && (cnt_r == TO_LAST)) begin
          timeout_s = 1'b1;
          state_s   = ST_RESP;
        end else if (TIMEOUT > 0) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and response registers
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rvalid_r <= (state_s == ST_RESP);
      err_r    <= (accept_s && misalign_s) || timeout_s;
      // rdata is cleared on acceptance so writes, errors and aborts return zero
      if (accept_s || timeout_s) begin
        rdata_r <= 32'h0000_0000;
      end else if ((state_r == ST_RD) && i_dram_ack) begin
        rdata_r <= load_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Request latches; the cluster's inputs are ignored once the access is accepted
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      addr_r  <= 32'h0000_0000;
      ctrl_r  <= 3'b000;
      wdata_r <= 32'h0000_0000;
      we_r    <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= i_addr;
      ctrl_r  <= i_ctrl;
      wdata_r <= i_wdata;
      we_r    <= i_we;
    end else begin
      addr_r  <= addr_r;
      ctrl_r  <= ctrl_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
    end
  end

  assign o_busy      = busy_s;
  assign o_rdata     = rdata_r;
  assign o_rvalid    = rvalid_r;
  assign o_err       = err_r;
  assign o_dram_req  = (state_r == ST_RD) || (state_r == ST_WR);
  assign o_dram_we   = (state_r == ST_WR);
  assign o_dram_addr = {addr_r[31:2], 2'b00};

endmodule

// File: tb/tb_cluster_mem_bridge.sv
// Directed bench for cluster_mem_bridge with a short timeout; DRAM acks are
// driven by hand per transaction and results compared against fixed values.
module tb_cluster_mem_bridge;

  logic        CLK;
  logic        RST_X;
  logic [31:0] i_addr;
  logic [2:0]  i_ctrl;
  logic        i_re;
  logic        i_we;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_err;
  logic        o_dram_req;
  logic        o_dram_we;
  logic [31:0] o_dram_addr;
  logic [3:0]  o_dram_be;
  logic [31:0] o_dram_wdata;
  logic        i_dram_ack;
  logic [31:0] i_dram_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic        b_we;
  logic [3:0]  b_be;
  logic [31:0] b_wd;
  logic [31:0] b_addr;
  int          b_cycles;
  logic [31:0] mem_word;

  cluster_mem_bridge #(.TIMEOUT(8), .RMW_EN(1'b1)) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .i_addr       (i_addr),
    .i_ctrl       (i_ctrl),
    .i_re         (i_re),
    .i_we         (i_we),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_rdata      (o_rdata),
    .o_rvalid     (o_rvalid),
    .o_err        (o_err),
    .o_dram_req   (o_dram_req),
    .o_dram_we    (o_dram_we),
    .o_dram_addr  (o_dram_addr),
    .o_dram_be    (o_dram_be),
    .o_dram_wdata (o_dram_wdata),
    .i_dram_ack   (i_dram_ack),
    .i_dram_rdata (i_dram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a request at a negedge, confirm the stall, then scramble the inputs.
  task automatic issue(input logic [31:0] addr, input logic [2:0] ctrl,
                       input logic re, input logic we, input logic [31:0] wd);
    @(negedge CLK);
    i_addr = addr; i_ctrl = ctrl; i_re = re; i_we = we; i_wdata = wd;
    #1 check_val("busy_accept", {31'd0, o_busy}, 32'd1);
    @(posedge CLK);
    #1;
    i_re = 1'b0; i_we = 1'b0;
    i_addr = 32'hFFFF_FFFF; i_ctrl = 3'b111; i_wdata = 32'hA5A5_A5A5;
  endtask

  // Serve one DRAM beat, acking on the ack_after-th cycle of req.
  task automatic beat(input int ack_after, input logic [31:0] rd);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge CLK);
      if (o_dram_req) begin
        n++;
        if (n == ack_after) begin
          i_dram_ack = 1'b1; i_dram_rdata = rd;
          b_we = o_dram_we; b_be = o_dram_be; b_wd = o_dram_wdata; b_addr = o_dram_addr;
          got = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
    i_dram_ack = 1'b0; i_dram_rdata = 32'h0BAD_0BAD;
    check_val("beat_seen", {31'd0, got}, 32'd1);
    b_cycles = n;
  endtask

  // Check the single response cycle and the idle cycle after it.
  task automatic resp(input logic exp_err, input logic [31:0] exp_rdata);
    @(negedge CLK);
    check_val("rvalid", {31'd0, o_rvalid}, 32'd1);
    check_val("err", {31'd0, o_err}, {31'd0, exp_err});
    check_val("rdata", o_rdata, exp_rdata);
    check_val("busy_resp", {31'd0, o_busy}, 32'd0);
    check_val("req_resp", {31'd0, o_dram_req}, 32'd0);
    @(negedge CLK);
    check_val("rvalid_drop", {31'd0, o_rvalid}, 32'd0);
  endtask

  initial begin
    int n;
    RST_X = 1'b0;
    i_addr = 32'h0; i_ctrl = 3'b000; i_re = 1'b0; i_we = 1'b0; i_wdata = 32'h0;
    i_dram_ack = 1'b0; i_dram_rdata = 32'h0;
    b_we = 1'b0; b_be = 4'h0; b_wd = 32'h0; b_addr = 32'h0; b_cycles = 0; mem_word = 32'h7;
    repeat (2) @(negedge CLK);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_req", {31'd0, o_dram_req}, 32'd0);
    check_val("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
    check_val("rst_rdata", o_rdata, 32'h0);
    RST_X = 1'b1;

    // LW, ack on third req cycle
    issue(32'h8000_0010, 3'b010, 1'b1, 1'b0, 32'h0);
    beat(3, 32'hDEAD_BEEF);
    check_val("lw_cycles", b_cycles, 32'd3);
    check_val("lw_be", {28'd0, b_be}, 32'hF);
    check_val("lw_addr", b_addr, 32'h8000_0010);
    check_val("lw_we", {31'd0, b_we}, 32'd0);
    resp(1'b0, 32'hDEAD_BEEF);

    // LB / LBU on byte 3
    issue(32'h0000_0103, 3'b000, 1'b1, 1'b0, 32'h0);
    beat(1, 32'h8012_3456);
    check_val("lb_be", {28'd0, b_be}, 32'h8);
    check_val("lb_addr", b_addr, 32'h0000_0100);
    resp(1'b0, 32'hFFFF_FF80);
    issue(32'h0000_0103, 3'b100, 1'b1, 1'b0, 32'h0);
    beat(2, 32'h8012_3456);
    resp(1'b0, 32'h0000_0080);

    // LH low half, sign-extended
    issue(32'h0000_0200, 3'b001, 1'b1, 1'b0, 32'h0);
    beat(1, 32'h1234_F00D);
    check_val("lh_be", {28'd0, b_be}, 32'h3);
    resp(1'b0, 32'hFFFF_F00D);

    // SH to upper half
    issue(32'h0000_0302, 3'b001, 1'b0, 1'b1, 32'h0000_1234);
    beat(1, 32'h0);
    check_val("sh_we", {31'd0, b_we}, 32'd1);
    check_val("sh_be", {28'd0, b_be}, 32'hC);
    check_val("sh_wd", b_wd, 32'h1234_1234);
    resp(1'b0, 32'h0);

    // SB to byte 1
    issue(32'h0000_0401, 3'b000, 1'b0, 1'b1, 32'h0000_00AB);
    beat(1, 32'h0);
    check_val("sb_be", {28'd0, b_be}, 32'h2);
    check_val("sb_wd", b_wd, 32'hABAB_ABAB);
    resp(1'b0, 32'h0);

    // RMW SW: old 7, new 5
    issue(32'h0000_0508, 3'b010, 1'b1, 1'b1, 32'h0000_0005);
    beat(1, mem_word);
    check_val("rmw_rd_we", {31'd0, b_we}, 32'd0);
    check_val("rmw_rd_be", {28'd0, b_be}, 32'hF);
    beat(1, 32'h0);
    check_val("rmw_wr_we", {31'd0, b_we}, 32'd1);
    mem_word = b_wd;
    check_val("rmw_mem", mem_word, 32'h5);
    resp(1'b0, 32'h7);

    // Misaligned LW: no DRAM traffic, error response next cycle
    issue(32'h0000_0602, 3'b010, 1'b1, 1'b0, 32'h0);
    resp(1'b1, 32'h0);

    // Timeout: no ack at all
    issue(32'h0000_0720, 3'b010, 1'b1, 1'b0, 32'h0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (o_dram_req) n++;
      else break;
    end
    check_val("to_cycles", n, 32'd8);
    check_val("to_rvalid", {31'd0, o_rvalid}, 32'd1);
    check_val("to_err", {31'd0, o_err}, 32'd1);
    check_val("to_rdata", o_rdata, 32'h0);
    @(negedge CLK);
    check_val("to_err_drop", {31'd0, o_err}, 32'd0);

    // Late ack while idle is ignored
    i_dram_ack = 1'b1;
    @(negedge CLK);
    i_dram_ack = 1'b0;
    check_val("late_ack_req", {31'd0, o_dram_req}, 32'd0);
    check_val("late_ack_rvalid", {31'd0, o_rvalid}, 32'd0);

    // Reset in the middle of a read
    issue(32'h0000_0800, 3'b010, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    check_val("mid_rd_req", {31'd0, o_dram_req}, 32'd1);
    #1 RST_X = 1'b0;
    #1;
    check_val("arst_req", {31'd0, o_dram_req}, 32'd0);
    check_val("arst_we", {31'd0, o_dram_we}, 32'd0);
    check_val("arst_busy", {31'd0, o_busy}, 32'd0);
    check_val("arst_rvalid", {31'd0, o_rvalid}, 32'd0);
    check_val("arst_err", {31'd0, o_err}, 32'd0);
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    check_val("post_rst_req", {31'd0, o_dram_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
